// File: rtl/window_gen_pkg.sv
// rtl/window_gen_pkg.sv - shared pixel type and window geometry for window_gen and the binarizer
//
// Contents:
//   DATA_W     - bits per channel sample
//   CORE_SIZE  - elements per 3x3 window
//   WIN_DIM    - rows/columns per window
//   pixel_t    - one signed channel sample
//   win_idx()  - flat window index for (window row, window column)
package window_gen_pkg;

  localparam int DATA_W    = 16;
  localparam int CORE_SIZE = 9;
  localparam int WIN_DIM   = 3;

  typedef logic signed [DATA_W-1:0] pixel_t;

  // Row 0 is the oldest row, column 0 the leftmost; index 8 is the newest pixel.
  function automatic int win_idx(input int wr, input int wc);
    return WIN_DIM * wr + wc;
  endfunction

endpackage

// File: rtl/window_gen_line_buf.sv
// rtl/window_gen_line_buf.sv - one feature-map row of delay, all channels of a pixel per entry
//
// Ports:
//   clk   - rising-edge clock
//   en    - shift strobe, one entry per accepted pixel
//   din   - pixel entering the row delay
//   dout  - pixel accepted DEPTH strobes earlier (same column, previous row)
module line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Contents are never reset: the window valid logic guarantees that stale
  // entries are only ever read while the window is not flagged valid.
  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// rtl/window_gen.sv - raster-order pixel stream to 3x3 sliding windows per channel
//
// Ports:
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset, wins over data_in_valid
//   data_in_valid  - one pixel accepted per asserted cycle
//   data_in        - all FM_DEPTH channels of the current pixel
//   data_out       - 3x3 window per channel, element 3*wr+wc
//   data_out_valid - data_out holds a new fully-inside window this cycle
//   frame_done     - pulses with the window of the last pixel of a frame
module window_gen
  import window_gen_pkg::pixel_t;
  import window_gen_pkg::DATA_W;
  import window_gen_pkg::WIN_DIM;
  import window_gen_pkg::win_idx;
#(
  parameter int FM_DEPTH  = 64,
  parameter int CORE_SIZE = 9,
  parameter int FM_WIDTH  = 32,
  parameter int FM_HEIGHT = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    data_in_valid,
  input  pixel_t [FM_DEPTH-1:0]                   data_in,
  output pixel_t [FM_DEPTH-1:0][CORE_SIZE-1:0]    data_out,
  output logic                                    data_out_valid,
  output logic                                    frame_done
);

  localparam int PIX_W = FM_DEPTH * DATA_W;
  localparam int COL_W = $clog2(FM_WIDTH);
  localparam int ROW_W = $clog2(FM_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FM_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FM_HEIGHT - 1);
  // First column/row index at which all three window columns/rows lie
  // inside the current frame and row.
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIN_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(WIN_DIM - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             accept;
  logic             win_full;
  logic             last_pixel;

  logic [PIX_W-1:0] lb0_dout;
  logic [PIX_W-1:0] lb1_dout;
  pixel_t [FM_DEPTH-1:0] lb0_px;
  pixel_t [FM_DEPTH-1:0] lb1_px;

  pixel_t [FM_DEPTH-1:0][CORE_SIZE-1:0] win;
  pixel_t [FM_DEPTH-1:0][CORE_SIZE-1:0] win_next;

  assign accept     = data_in_valid && !rst;
  assign win_full   = (row >= ROW_FULL) && (col >= COL_FULL);
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  // lb0 delays the input by one row, lb1 by two rows.
  line_buf #(
    .DEPTH (FM_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk  (clk),
    .en   (accept),
    .din  (data_in),
    .dout (lb0_dout)
  );

  line_buf #(
    .DEPTH (FM_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  assign lb0_px = lb0_dout;
  assign lb1_px = lb1_dout;

  // Window after the current pixel: every row shifts left by one column and
  // the rightmost column is {two rows up, one row up, current pixel}.
  always_comb begin
    win_next = win;
    for (int ch = 0; ch < FM_DEPTH; ch++) begin
      for (int wr = 0; wr < WIN_DIM; wr++) begin
        for (int wc = 0; wc < WIN_DIM - 1; wc++) begin
          win_next[ch][win_idx(wr, wc)] = win[ch][win_idx(wr, wc + 1)];
        end
      end
      win_next[ch][win_idx(0, WIN_DIM - 1)] = lb1_px[ch];
      win_next[ch][win_idx(1, WIN_DIM - 1)] = lb0_px[ch];
      win_next[ch][win_idx(2, WIN_DIM - 1)] = data_in[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row            <= '0;
      col            <= '0;
      win            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_out_valid <= data_in_valid && win_full;
      frame_done     <= data_in_valid && last_pixel;
      if (data_in_valid) begin
        win <= win_next;
        // data_out only updates on real windows so it holds between them.
        if (win_full) begin
          data_out <= win_next;
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - self-checking bench for window_gen against a frame-array model
module tb_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 2;

  typedef logic [D-1:0][8:0][15:0] win_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            data_in_valid = 1'b0;
  logic [D-1:0][15:0] data_in = '0;
  win_t            data_out;
  logic            data_out_valid;
  logic            frame_done;

  window_gen #(
    .FM_DEPTH  (D),
    .CORE_SIZE (9),
    .FM_WIDTH  (W),
    .FM_HEIGHT (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  bit armed  = 0;

  // Model: the frame so far as a plain 2-D array; a window is read straight
  // out of it whenever the pixel just accepted completes a 3x3 block.
  logic [15:0] fr [H][W][D];
  int   m_row = 0;
  int   m_col = 0;
  logic exp_valid = 1'b0;
  logic exp_done  = 1'b0;
  win_t exp_out   = '0;

  win_t dut_log[$];
  int   done_cnt;
  int   px22_cyc;
  int   first_valid_cyc;

  int W_FIRST [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
  int W_LAST  [9] = '{17, 18, 19, 33, 34, 35, 49, 50, 51};
  int W_F2    [9] = '{100, 101, 102, 116, 117, 118, 132, 133, 134};

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
  endtask

  task automatic chk_win(input string nm, input logic [8:0][15:0] got,
                         input int e [9], input int sgn);
    logic [8:0][15:0] ev;
    for (int j = 0; j < 9; j++) ev[j] = 16'(sgn * e[j]);
    total++;
    if (got == ev) passed++;
    else $display("FAIL %s got=%h expected=%h", nm, got, ev);
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_row = 0; m_col = 0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_out = '0;
      end else if (data_in_valid) begin
        for (int ch = 0; ch < D; ch++) fr[m_row][m_col][ch] = data_in[ch];
        exp_valid = (m_row >= 2) && (m_col >= 2);
        exp_done  = (m_row == H - 1) && (m_col == W - 1);
        if (exp_valid)
          for (int ch = 0; ch < D; ch++)
            for (int j = 0; j < 9; j++)
              exp_out[ch][j] = fr[m_row - 2 + j / 3][m_col - 2 + j % 3][ch];
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
      end else begin
        exp_valid = 1'b0; exp_done = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("data_out_valid", data_out_valid, exp_valid);
        chk("frame_done", frame_done, exp_done);
        total++;
        if (data_out == exp_out) passed++;
        else $display("FAIL data_out cyc=%0d got=%h expected=%h", cyc, data_out, exp_out);
        if (data_out_valid) begin
          dut_log.push_back(data_out);
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic clear_logs();
    dut_log.delete();
    done_cnt = 0;
    px22_cyc = -1;
    first_valid_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int off, input int gap, input int npx);
    for (int p = 0; p < npx; p++) begin
      int r, c, v;
      r = p / W; c = p % W;
      v = 16 * r + c + off;
      data_in[0] = 16'(v);
      data_in[1] = 16'(-v);
      data_in_valid = 1'b1;
      if (r == 2 && c == 2 && px22_cyc < 0) px22_cyc = cyc;
      tick();
      data_in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_single_frame(input string tag);
    chk({tag, "_win_count"}, dut_log.size(), 4);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_first_latency"}, first_valid_cyc - px22_cyc, 1);
    if (dut_log.size() == 4) begin
      chk_win({tag, "_first_ch0"}, dut_log[0][0], W_FIRST, 1);
      chk_win({tag, "_first_ch1"}, dut_log[0][1], W_FIRST, -1);
      chk_win({tag, "_last_ch0"},  dut_log[3][0], W_LAST, 1);
    end
  endtask

  initial begin : stimulus
    clear_logs();
    rst = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    chk("reset_valid", data_out_valid, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_data_any", |data_out, 0);
    rst = 1'b0;

    clear_logs();
    send_frame(0, 0, 16);
    repeat (3) tick();
    check_single_frame("b2b");

    clear_logs();
    send_frame(0, 3, 16);
    repeat (3) tick();
    check_single_frame("gap3");

    clear_logs();
    send_frame(0, 0, 16);
    send_frame(100, 0, 16);
    repeat (3) tick();
    chk("two_frames_win_count", dut_log.size(), 8);
    chk("two_frames_done_count", done_cnt, 2);
    if (dut_log.size() == 8) chk_win("frame2_first_ch0", dut_log[4][0], W_F2, 1);

    clear_logs();
    send_frame(0, 0, 10);
    rst = 1'b1;
    data_in_valid = 1'b1;
    data_in[0] = 16'h1234;
    data_in[1] = 16'h5678;
    tick();
    rst = 1'b0;
    data_in_valid = 1'b0;
    tick();
    chk("no_valid_before_reset", dut_log.size(), 0);
    clear_logs();
    send_frame(0, 0, 16);
    repeat (3) tick();
    check_single_frame("post_rst");

    clear_logs();
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        data_in_valid = 1'($urandom_range(0, 1));
        tick();
        rst = 1'b0;
      end
      data_in[0] = 16'($urandom);
      data_in[1] = 16'($urandom);
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
